// File: rtl/debug_unit_ctrl_if.sv
// rtl/debug_unit_ctrl_if.sv - host link, load, pipeline and dump bus bundle for debug_unit_ctrl
interface debug_unit_ctrl_if #(
  parameter int NB_ADDR = 8
);
  logic [7:0]         i_rx_data;
  logic               i_rx_valid;
  logic [7:0]         o_tx_data;
  logic               o_tx_start;
  logic               i_tx_done;
  logic [31:0]        o_inst_load;
  logic [NB_ADDR-1:0] o_addr_inst_load;
  logic               o_en_write;
  logic               o_debug_unit;
  logic               o_enable_pipe;
  logic               o_en_read;
  logic               i_halt;
  logic [NB_ADDR-1:0] i_data_send_pc;
  logic [NB_ADDR-1:0] i_count_cycles;
  logic [4:0]         o_addr_debug_unit;
  logic [31:0]        i_data_reg_debug_unit;
  logic [NB_ADDR-1:0] o_addr_mem_debug_unit;
  logic [31:0]        i_data_mem_debug_unit;

  modport master (
    input  i_rx_data, i_rx_valid, i_tx_done, i_halt, i_data_send_pc, i_count_cycles,
           i_data_reg_debug_unit, i_data_mem_debug_unit,
    output o_tx_data, o_tx_start, o_inst_load, o_addr_inst_load, o_en_write, o_debug_unit,
           o_enable_pipe, o_en_read, o_addr_debug_unit, o_addr_mem_debug_unit
  );

  modport slave (
    output i_rx_data, i_rx_valid, i_tx_done, i_halt, i_data_send_pc, i_count_cycles,
           i_data_reg_debug_unit, i_data_mem_debug_unit,
    input  o_tx_data, o_tx_start, o_inst_load, o_addr_inst_load, o_en_write, o_debug_unit,
           o_enable_pipe, o_en_read, o_addr_debug_unit, o_addr_mem_debug_unit
  );
endinterface

// File: rtl/debug_unit_ctrl.sv
// rtl/debug_unit_ctrl.sv - debug unit FSM: program load, run/step control and state dump
module debug_unit_ctrl #(
  parameter int NB_ADDR    = 8,
  parameter int N_MEM_DUMP = 16
) (
  input  logic              clock,
  input  logic              i_reset_n,
  debug_unit_ctrl_if.master bus
);
  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] LOAD_BYTE  = 3'd1;
  localparam logic [2:0] LOAD_WRITE = 3'd2;
  localparam logic [2:0] RUN        = 3'd3;
  localparam logic [2:0] STEP       = 3'd4;
  localparam logic [2:0] DUMP_FETCH = 3'd5;
  localparam logic [2:0] DUMP_SEND  = 3'd6;
  localparam logic [2:0] DUMP_WAIT  = 3'd7;

  // Dump fields: 0 = PC, 1 = cycle count, 2..33 = registers, then memory words
  localparam int            N_FIELDS   = 34 + N_MEM_DUMP;
  localparam int            FW         = $clog2(N_FIELDS);
  localparam logic [FW-1:0] FIRST_REG  = FW'(2);
  localparam logic [FW-1:0] FIRST_MEM  = FW'(34);
  localparam logic [FW-1:0] LAST_FIELD = FW'(N_FIELDS - 1);
  localparam logic [5:0]    HALT_OP    = 6'b111111;

  logic [2:0]    state;
  logic [1:0]    byte_cnt;
  logic [23:0]   load_word;
  logic [31:0]   tx_word;
  logic [31:0]   fetch_word;
  logic [FW-1:0] field;
  logic          fetch_ph;

  always_comb begin
    fetch_word = bus.i_data_mem_debug_unit;
    if (field == '0)
      fetch_word = 32'(bus.i_data_send_pc);
    else if (field == FW'(1))
      fetch_word = 32'(bus.i_count_cycles);
    else if (field < FIRST_MEM)
      fetch_word = bus.i_data_reg_debug_unit;
  end

  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state                     <= IDLE;
      byte_cnt                  <= '0;
      load_word                 <= '0;
      tx_word                   <= '0;
      field                     <= '0;
      fetch_ph                  <= 1'b0;
      bus.o_tx_data             <= '0;
      bus.o_tx_start            <= 1'b0;
      bus.o_inst_load           <= '0;
      bus.o_addr_inst_load      <= '0;
      bus.o_en_write            <= 1'b0;
      bus.o_debug_unit          <= 1'b0;
      bus.o_enable_pipe         <= 1'b0;
      bus.o_en_read             <= 1'b0;
      bus.o_addr_debug_unit     <= '0;
      bus.o_addr_mem_debug_unit <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_rx_valid) begin
            case (bus.i_rx_data)
              8'h01: begin
                state                <= LOAD_BYTE;
                bus.o_debug_unit     <= 1'b1;
                bus.o_addr_inst_load <= '0;
                byte_cnt             <= '0;
              end
              8'h02: begin
                state             <= RUN;
                bus.o_enable_pipe <= 1'b1;
                bus.o_en_read     <= 1'b1;
              end
              8'h03: begin
                state             <= STEP;
                bus.o_enable_pipe <= 1'b1;
                bus.o_en_read     <= 1'b1;
              end
              default: state <= IDLE;
            endcase
          end
        end
        LOAD_BYTE: begin
          if (bus.i_rx_valid) begin
            load_word <= {load_word[15:0], bus.i_rx_data};
            byte_cnt  <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              bus.o_inst_load <= {load_word, bus.i_rx_data};
              bus.o_en_write  <= 1'b1;
              state           <= LOAD_WRITE;
            end
          end
        end
        LOAD_WRITE: begin
          bus.o_en_write       <= 1'b0;
          bus.o_addr_inst_load <= bus.o_addr_inst_load + NB_ADDR'(1);
          if (bus.o_inst_load[31:26] == HALT_OP) begin
            state            <= IDLE;
            bus.o_debug_unit <= 1'b0;
          end else begin
            state <= LOAD_BYTE;
          end
        end
        RUN: begin
          if (bus.i_halt) begin
            bus.o_enable_pipe <= 1'b0;
            bus.o_en_read     <= 1'b0;
            fetch_ph          <= 1'b0;
            state             <= DUMP_FETCH;
          end
        end
        STEP: begin
          bus.o_enable_pipe <= 1'b0;
          bus.o_en_read     <= 1'b0;
          fetch_ph          <= 1'b0;
          state             <= DUMP_FETCH;
        end
        DUMP_FETCH: begin
          // First cycle lets the read address settle; the word is taken on the second
          if (!fetch_ph) begin
            fetch_ph <= 1'b1;
          end else begin
            bus.o_tx_data  <= fetch_word[31:24];
            tx_word        <= {fetch_word[23:0], 8'h00};
            bus.o_tx_start <= 1'b1;
            byte_cnt       <= '0;
            state          <= DUMP_SEND;
            if (field >= FIRST_MEM)
              bus.o_addr_mem_debug_unit <= bus.o_addr_mem_debug_unit + NB_ADDR'(1);
            else if (field >= FIRST_REG)
              bus.o_addr_debug_unit <= bus.o_addr_debug_unit + 5'd1;
          end
        end
        DUMP_SEND: begin
          bus.o_tx_start <= 1'b0;
          state          <= DUMP_WAIT;
        end
        DUMP_WAIT: begin
          if (bus.i_tx_done) begin
            if (byte_cnt != 2'd3) begin
              byte_cnt       <= byte_cnt + 2'd1;
              bus.o_tx_data  <= tx_word[31:24];
              tx_word        <= tx_word << 8;
              bus.o_tx_start <= 1'b1;
              state          <= DUMP_SEND;
            end else if (field == LAST_FIELD) begin
              field                     <= '0;
              bus.o_addr_debug_unit     <= '0;
              bus.o_addr_mem_debug_unit <= '0;
              state                     <= IDLE;
            end else begin
              field    <= field + FW'(1);
              fetch_ph <= 1'b0;
              state    <= DUMP_FETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_debug_unit_ctrl.sv
// tb/tb_debug_unit_ctrl.sv - directed self-checking bench for debug_unit_ctrl
module tb_debug_unit_ctrl;
  localparam int NB_ADDR    = 8;
  localparam int N_MEM_DUMP = 16;
  localparam int N_BYTES    = 8 + 128 + 4 * N_MEM_DUMP;

  logic clock = 1'b0;
  logic i_reset_n;

  debug_unit_ctrl_if #(.NB_ADDR(NB_ADDR)) bus ();

  debug_unit_ctrl #(.NB_ADDR(NB_ADDR), .N_MEM_DUMP(N_MEM_DUMP)) dut (
    .clock     (clock),
    .i_reset_n (i_reset_n),
    .bus       (bus)
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;

  function automatic logic [31:0] reg_val(input logic [4:0] a);
    if (a == 5'd4) return 32'h0000001E;
    return {3'b100, a, 8'h11, 8'h22, 3'b000, a};
  endfunction

  function automatic logic [31:0] mem_val(input logic [7:0] a);
    return {8'hD0, a, 8'h5A, ~a};
  endfunction

  function automatic logic [7:0] exp_byte(input int i, input logic [31:0] pc, input logic [31:0] cyc);
    logic [31:0] w;
    int k;
    if (i < 4)        w = pc;
    else if (i < 8)   w = cyc;
    else if (i < 136) w = reg_val(5'((i - 8) / 4));
    else              w = mem_val(8'((i - 136) / 4));
    k = 3 - (i % 4);
    return w[k*8 +: 8];
  endfunction

  // Register file and data memory: one-cycle read latency
  always @(posedge clock) begin
    bus.i_data_reg_debug_unit <= reg_val(bus.o_addr_debug_unit);
    bus.i_data_mem_debug_unit <= mem_val(bus.o_addr_mem_debug_unit);
  end

  int               tx_delay        = 1;
  bit               same_cycle_done = 1'b0;
  int               tx_count        = 0;
  int               overlap         = 0;
  int               en_cycles       = 0;
  int               rd_cycles       = 0;
  int               wr_count        = 0;
  int               done_cnt        = 0;
  bit               pending         = 1'b0;
  logic [7:0]       tx_log  [0:2047];
  logic [NB_ADDR-1:0] wr_addr [0:63];
  logic [31:0]      wr_data [0:63];

  // Transmitter model and output monitor
  always @(negedge clock) begin
    if (bus.o_enable_pipe) en_cycles++;
    if (bus.o_en_read) rd_cycles++;
    if (bus.o_en_write) begin
      wr_addr[wr_count] = bus.o_addr_inst_load;
      wr_data[wr_count] = bus.o_inst_load;
      wr_count++;
    end
    bus.i_tx_done = 1'b0;
    if (!i_reset_n) begin
      pending  = 1'b0;
      done_cnt = 0;
    end else if (bus.o_tx_start) begin
      if (pending) overlap++;
      pending            = 1'b1;
      tx_log[tx_count]   = bus.o_tx_data;
      tx_count++;
      done_cnt           = tx_delay;
      if (same_cycle_done) bus.i_tx_done = 1'b1;
    end else if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) begin
        bus.i_tx_done = 1'b1;
        pending       = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    bus.i_rx_data  = b;
    bus.i_rx_valid = 1'b1;
    @(negedge clock);
    bus.i_rx_valid = 1'b0;
  endtask

  task automatic send_burst(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) begin
      @(negedge clock);
      bus.i_rx_data  = w[i*8 +: 8];
      bus.i_rx_valid = 1'b1;
    end
    @(negedge clock);
    bus.i_rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input int target, input int budget, input string tag);
    int i = 0;
    while (tx_count < target && i < budget) begin
      @(negedge clock);
      i++;
    end
    repeat (30) @(negedge clock);
    check(tag, 32'(tx_count), 32'(target));
  endtask

  task automatic check_stream(input int base, input logic [31:0] pc, input logic [31:0] cyc,
                              input string tag);
    int bad = 0;
    for (int i = 0; i < N_BYTES; i++)
      if (tx_log[base + i] !== exp_byte(i, pc, cyc)) bad++;
    check(tag, 32'(bad), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_start"},    32'(bus.o_tx_start), 32'd0);
    check({tag, "_en_write"},    32'(bus.o_en_write), 32'd0);
    check({tag, "_debug_unit"},  32'(bus.o_debug_unit), 32'd0);
    check({tag, "_enable_pipe"}, 32'(bus.o_enable_pipe), 32'd0);
    check({tag, "_en_read"},     32'(bus.o_en_read), 32'd0);
    check({tag, "_tx_data"},     32'(bus.o_tx_data), 32'd0);
    check({tag, "_inst_load"},   bus.o_inst_load, 32'd0);
    check({tag, "_addr_inst"},   32'(bus.o_addr_inst_load), 32'd0);
    check({tag, "_addr_reg"},    32'(bus.o_addr_debug_unit), 32'd0);
    check({tag, "_addr_mem"},    32'(bus.o_addr_mem_debug_unit), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tx_base;
    int en_base;
    int rd_base;
    int wr_base;

    i_reset_n          = 1'b0;
    bus.i_rx_data      = '0;
    bus.i_rx_valid     = 1'b0;
    bus.i_halt         = 1'b0;
    bus.i_data_send_pc = '0;
    bus.i_count_cycles = '0;
    repeat (3) @(negedge clock);
    check_reset_outputs("por");
    i_reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Unknown command byte and a stray halt in IDLE do nothing
    send_byte(8'h7F);
    @(negedge clock);
    bus.i_halt = 1'b1;
    @(negedge clock);
    bus.i_halt = 1'b0;
    repeat (5) @(negedge clock);
    check("idle_7f_debug", 32'(bus.o_debug_unit), 32'd0);
    check("idle_7f_enable", 32'(en_cycles), 32'd0);
    check("idle_7f_tx", 32'(tx_count), 32'd0);

    // Program load: one word byte by byte, the halt word as a back-to-back burst
    wr_base = wr_count;
    send_byte(8'h01);
    check("load_debug_on", 32'(bus.o_debug_unit), 32'd1);
    check("load_addr0", 32'(bus.o_addr_inst_load), 32'd0);
    send_byte(8'h3C);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h0A);
    send_burst(32'hFC000000);
    repeat (3) @(negedge clock);
    check("load_wr_count", 32'(wr_count - wr_base), 32'd2);
    check("load_wr0_addr", 32'(wr_addr[wr_base]), 32'd0);
    check("load_wr0_data", wr_data[wr_base], 32'h3C01000A);
    check("load_wr1_addr", 32'(wr_addr[wr_base + 1]), 32'd1);
    check("load_wr1_data", wr_data[wr_base + 1], 32'hFC000000);
    check("load_debug_off", 32'(bus.o_debug_unit), 32'd0);
    check("load_addr_next", 32'(bus.o_addr_inst_load), 32'd2);

    // Run until halt after 20 cycles, then the full dump
    bus.i_data_send_pc = 8'h0A;
    bus.i_count_cycles = 8'h21;
    tx_delay = 1;
    tx_base  = tx_count;
    en_base  = en_cycles;
    rd_base  = rd_cycles;
    send_byte(8'h02);
    repeat (19) @(negedge clock);
    bus.i_halt = 1'b1;
    @(negedge clock);
    bus.i_halt = 1'b0;
    check("run_enable_low", 32'(bus.o_enable_pipe), 32'd0);
    check("run_enable_cycles", 32'(en_cycles - en_base), 32'd20);
    check("run_read_cycles", 32'(rd_cycles - rd_base), 32'd20);
    while (tx_count < tx_base + 20) @(negedge clock);
    send_byte(8'h01);
    send_byte(8'h7F);
    bus.i_halt = 1'b1;
    @(negedge clock);
    bus.i_halt = 1'b0;
    wait_tx(tx_base + N_BYTES, 5000, "run_byte_count");
    check("run_pc_b0", 32'(tx_log[tx_base]), 32'h00);
    check("run_pc_b1", 32'(tx_log[tx_base + 1]), 32'h00);
    check("run_pc_b2", 32'(tx_log[tx_base + 2]), 32'h00);
    check("run_pc_b3", 32'(tx_log[tx_base + 3]), 32'h0A);
    check_stream(tx_base, 32'h0A, 32'h21, "run_stream");
    check("run_overlap", 32'(overlap), 32'd0);
    check("run_debug_during_dump", 32'(bus.o_debug_unit), 32'd0);
    check("run_no_restart", 32'(en_cycles - en_base), 32'd20);
    check("run_mem_addr_cleared", 32'(bus.o_addr_mem_debug_unit), 32'd0);

    // Single step; a done pulse coincident with each start must be ignored
    bus.i_data_send_pc = 8'h0B;
    bus.i_count_cycles = 8'h22;
    same_cycle_done = 1'b1;
    tx_base = tx_count;
    en_base = en_cycles;
    send_byte(8'h03);
    wait_tx(tx_base + N_BYTES, 5000, "step_byte_count");
    same_cycle_done = 1'b0;
    check("step_enable_cycles", 32'(en_cycles - en_base), 32'd1);
    check("step_r4_b0", 32'(tx_log[tx_base + 24]), 32'h00);
    check("step_r4_b1", 32'(tx_log[tx_base + 25]), 32'h00);
    check("step_r4_b2", 32'(tx_log[tx_base + 26]), 32'h00);
    check("step_r4_b3", 32'(tx_log[tx_base + 27]), 32'h1E);
    check_stream(tx_base, 32'h0B, 32'h22, "step_stream");
    check("step_overlap", 32'(overlap), 32'd0);

    // Backpressure: slow transmitter
    bus.i_data_send_pc = 8'h0C;
    bus.i_count_cycles = 8'h23;
    tx_delay = 10;
    tx_base  = tx_count;
    send_byte(8'h03);
    wait_tx(tx_base + N_BYTES, 8000, "bp_byte_count");
    check_stream(tx_base, 32'h0C, 32'h23, "bp_stream");
    check("bp_overlap", 32'(overlap), 32'd0);

    // Reset in the middle of a dump
    tx_delay = 1;
    tx_base  = tx_count;
    send_byte(8'h03);
    for (int i = 0; i < 2000 && tx_count < tx_base + 10; i++) @(negedge clock);
    @(negedge clock);
    #2 i_reset_n = 1'b0;
    @(negedge clock);
    check_reset_outputs("dump_rst");
    tx_base = tx_count;
    i_reset_n = 1'b1;
    repeat (100) @(negedge clock);
    check("dump_rst_no_tx", 32'(tx_count), 32'(tx_base));

    // Reset in the middle of a load; the next load restarts at address 0
    send_byte(8'h01);
    send_burst(32'h12345678);
    send_byte(8'hAA);
    send_byte(8'hBB);
    #2 i_reset_n = 1'b0;
    @(negedge clock);
    check_reset_outputs("load_rst");
    i_reset_n = 1'b1;
    wr_base = wr_count;
    send_byte(8'h01);
    send_burst(32'hFC000001);
    repeat (3) @(negedge clock);
    check("reload_wr_count", 32'(wr_count - wr_base), 32'd1);
    check("reload_addr", 32'(wr_addr[wr_base]), 32'd0);
    check("reload_data", wr_data[wr_base], 32'hFC000001);
    check("reload_debug_off", 32'(bus.o_debug_unit), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/debug_unit_ctrl.md
DEBUG_UNIT_CTRL -- requirements
Module: debug_unit_ctrl

Interface
REQ-001 Parameter NB_ADDR, default 8; width of the instruction-memory address, data-memory address, PC and cycle-count buses.
REQ-002 Parameter N_MEM_DUMP, default 16; number of data-memory words sent per dump, from address 0 upward.
REQ-003 clock  in  1  single clock; all state updates on the rising edge.
REQ-004 i_reset_n  in  1  asynchronous active-low reset.
REQ-005 i_rx_data  in  8  received byte.
REQ-006 i_rx_valid  in  1  one-cycle pulse; i_rx_data is valid in that cycle.
REQ-007 o_tx_data  out  8  byte to transmit.
REQ-008 o_tx_start  out  1  one-cycle pulse that launches a transmission of o_tx_data.
REQ-009 i_tx_done  in  1  one-cycle pulse marking the end of the current transmission.
REQ-010 o_inst_load  out  32  instruction word to write into instruction memory.
REQ-011 o_addr_inst_load  out  NB_ADDR  instruction-memory write address.
REQ-012 o_en_write  out  1  instruction-memory write strobe.
REQ-013 o_debug_unit  out  1  high while the pipeline is being loaded.
REQ-014 o_enable_pipe  out  1  pipeline advance enable.
REQ-015 o_en_read  out  1  instruction-memory fetch enable.
REQ-016 i_halt  in  1  pipeline has retired a halt instruction.
REQ-017 i_data_send_pc  in  NB_ADDR  current PC.
REQ-018 i_count_cycles  in  NB_ADDR  pipeline cycle counter.
REQ-019 o_addr_debug_unit  out  5  register-file read address.
REQ-020 i_data_reg_debug_unit  in  32  register-file read data; valid one cycle after the address is presented.
REQ-021 o_addr_mem_debug_unit  out  NB_ADDR  data-memory read address.
REQ-022 i_data_mem_debug_unit  in  32  data-memory read data; valid one cycle after the address is presented.

Function
REQ-023 States: IDLE, LOAD_BYTE, LOAD_WRITE, RUN, STEP, DUMP_FETCH, DUMP_SEND, DUMP_WAIT.
REQ-024 IDLE accepts these command bytes on i_rx_valid; all other bytes are ignored and the state stays IDLE:
  - 0x01 -> LOAD_BYTE; o_debug_unit=1; o_addr_inst_load=0; byte count=0.
  - 0x02 -> RUN.
  - 0x03 -> STEP.
REQ-025 LOAD_BYTE shifts each received byte into the word, MSB first. The 4th byte moves the state to LOAD_WRITE.
REQ-026 LOAD_WRITE lasts one cycle:
  - o_en_write=1 and o_inst_load=the assembled word.
  - The next cycle o_en_write=0 and o_addr_inst_load increments by 1, wrapping from 2^NB_ADDR-1 to 0.
REQ-027 If the written word has [31:26]=6'b111111 (halt), the block returns to IDLE with o_debug_unit=0. Otherwise it returns to LOAD_BYTE.
REQ-028 RUN holds o_enable_pipe=1 and o_en_read=1 until i_halt=1 is sampled. It then drops both in the next cycle and goes to DUMP_FETCH.
REQ-029 STEP asserts o_enable_pipe=1 and o_en_read=1 for exactly one cycle, then goes to DUMP_FETCH regardless of i_halt.
REQ-030 Dump byte stream, each field MSB first:
  - PC zero-extended to 32 bits (4 bytes).
  - Cycle count zero-extended to 32 bits (4 bytes).
  - Registers 0..31 (4 bytes each).
  - Memory words 0..N_MEM_DUMP-1 (4 bytes each).
  - Total 8+128+4*N_MEM_DUMP bytes; 200 at the default.
REQ-031 DUMP_FETCH presents the address and latches the 32-bit word one cycle later.
REQ-032 For each of the 4 bytes of the latched word:
  - DUMP_SEND drives o_tx_data and pulses o_tx_start for one cycle.
  - DUMP_WAIT then holds until i_tx_done.
REQ-033 After the last byte the block returns to IDLE. The register and memory address counters reset to 0.
REQ-034 i_rx_valid is ignored outside IDLE and LOAD_BYTE. i_halt is ignored outside RUN.
REQ-035 i_tx_done outside DUMP_WAIT is ignored. i_tx_done in the same cycle as o_tx_start is not counted.
REQ-036 A simultaneous i_rx_valid and 4th-byte arrival in LOAD_BYTE is one event; no byte is lost or double-counted.

Reset
REQ-037 Asynchronous reset returns the FSM to IDLE and forces these outputs:
  - o_tx_start, o_en_write, o_debug_unit, o_enable_pipe and o_en_read = 0.
  - o_tx_data = 0 and o_inst_load = 0.
  - o_addr_inst_load, o_addr_debug_unit and o_addr_mem_debug_unit = 0.
REQ-038 Reset during a load discards any partial word, and the next LOAD restarts at address 0. Reset during a dump aborts it with no further o_tx_start.

Verification
REQ-039 Load: 0x01, 3C 01 00 0A, FC 00 00 00 -> two o_en_write pulses:
  - addr 0, 0x3C01000A.
  - addr 1, 0xFC000000.
  - Then o_debug_unit=0 and the state is IDLE.
REQ-040 Run: 0x02, then i_halt after 20 cycles -> o_enable_pipe high exactly until the cycle after i_halt, followed by 200 o_tx_start pulses. First 4 bytes = PC MSB first (e.g. PC=0x0A -> 00 00 00 0A).
REQ-041 Step: 0x03 -> o_enable_pipe high for exactly 1 cycle, then a full 200-byte dump. Register r4=0x0000001E appears at stream bytes 24..27.
REQ-042 Backpressure: i_tx_done delayed 10 cycles per byte -> no o_tx_start issued before the previous i_tx_done, and byte order unchanged.
REQ-043 Reset mid-load: reset after 2 bytes of the second word -> outputs at reset values. A new load writes its first word at addr 0.
REQ-044 Illegal/idle bytes: 0x7F in IDLE and any byte during a dump -> no state change and no stream corruption.
